prompt_sequencer: RTL and testbench

Quiz-flow controller that sequences the per-prompt sprite controllers (q1, q2, …) on the VGA path. It drives their one-hot enables and the shared background colour. It runs a per-prompt frame-based timer, collects an answer handshake, keeps score, and shows a green/red feedback flash. All visible changes take effect only at frame boundaries, so a prompt never tears mid-frame.

---
 rtl/vga_quiz_pkg.sv | 20 ++
 rtl/frame_tick_gen.sv | 23 ++
 rtl/prompt_sequencer.sv | 142 ++++++++++++++
 tb/tb_prompt_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_quiz_pkg.sv
// Shared definitions for the VGA quiz controllers: quiz state encoding,
// palette constants and default 640x480@60 timing totals.
package vga_quiz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHOW     = 2'd1,
    ST_FEEDBACK = 2'd2,
    ST_DONE     = 2'd3
  } quiz_state_t;

  localparam logic [11:0] COLOR_WHITE   = 12'hFFF;
  localparam logic [11:0] COLOR_BG_OK   = 12'h0F0;
  localparam logic [11:0] COLOR_BG_BAD  = 12'hF00;
  localparam logic [11:0] COLOR_BG_IDLE = 12'h000;

  localparam int VGA_H_TOTAL = 800;
  localparam int VGA_V_TOTAL = 525;

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame_tick, registered, high in the cycle after the last pixel
// of the last line. Reusable by any controller that keys off hCount/vCount.
module frame_tick_gen #(
  parameter int H_TOTAL = vga_quiz_pkg::VGA_H_TOTAL,
  parameter int V_TOTAL = vga_quiz_pkg::VGA_V_TOTAL,
  parameter int CW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] hCount,
  input  logic [CW-1:0] vCount,
  output logic          frame_tick
);

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_tick <= 1'b0;
    else      frame_tick <= (hCount == H_LAST) && (vCount == V_LAST);
  end

endmodule

// File: rtl/prompt_sequencer.sv
// Quiz-flow controller: walks the prompt controllers one at a time, times each
// prompt in frames, latches the answer, keeps score and flashes feedback.
module prompt_sequencer
  import vga_quiz_pkg::*;
#(
  parameter int          NUM_Q       = 3,
  parameter int          IDX_W       = 3,
  parameter int          CNT_W       = 10,
  parameter int          TIME_FRAMES = 600,
  parameter int          FB_FRAMES   = 60,
  parameter int          H_TOTAL     = VGA_H_TOTAL,
  parameter int          V_TOTAL     = VGA_V_TOTAL,
  parameter logic [11:0] BG_IDLE     = COLOR_BG_IDLE,
  parameter logic [11:0] BG_OK       = COLOR_BG_OK,
  parameter logic [11:0] BG_BAD      = COLOR_BG_BAD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       hCount,
  input  logic [9:0]       vCount,
  input  logic             start,
  input  logic             answer_valid,
  input  logic             answer_correct,
  output logic [NUM_Q-1:0] q_en,
  output logic [IDX_W-1:0] q_idx,
  output logic [11:0]      background,
  output logic [IDX_W:0]   score,
  output logic [CNT_W-1:0] frames_left,
  output logic             done
);

  localparam logic [CNT_W-1:0] TIME_LOAD = CNT_W'(TIME_FRAMES);
  localparam logic [CNT_W-1:0] FB_LOAD   = CNT_W'(FB_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_Q    = IDX_W'(NUM_Q - 1);
  localparam logic [IDX_W:0]   SCORE_MAX = '1;
  localparam logic [NUM_Q-1:0] FIRST_EN  = NUM_Q'(1);

  logic             frame_tick;
  quiz_state_t      state;
  logic             start_pend;
  logic             ans_pend;
  logic             ans_ok;
  logic [CNT_W-1:0] fb_cnt;
  logic             answer_now;
  logic             answer_good;

  frame_tick_gen #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .CW      (10)
  ) u_frame_tick (
    .clk        (clk),
    .rst        (rst),
    .hCount     (hCount),
    .vCount     (vCount),
    .frame_tick (frame_tick)
  );

  // An answer arriving in the tick cycle itself still counts for this prompt.
  assign answer_now  = ans_pend | answer_valid;
  assign answer_good = ans_pend ? ans_ok : answer_correct;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      q_en        <= '0;
      q_idx       <= '0;
      background  <= BG_IDLE;
      score       <= '0;
      frames_left <= '0;
      done        <= 1'b0;
      start_pend  <= 1'b0;
      ans_pend    <= 1'b0;
      ans_ok      <= 1'b0;
      fb_cnt      <= '0;
    end else begin
      if (start && (state == ST_IDLE || state == ST_DONE))
        start_pend <= 1'b1;
      if (answer_valid && state == ST_SHOW && !ans_pend) begin
        ans_pend <= 1'b1;
        ans_ok   <= answer_correct;
      end

      if (frame_tick) begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start_pend) begin
              state       <= ST_SHOW;
              q_idx       <= '0;
              q_en        <= FIRST_EN;
              frames_left <= TIME_LOAD;
              score       <= '0;
              done        <= 1'b0;
              background  <= BG_IDLE;
              start_pend  <= 1'b0;
            end
          end
          ST_SHOW: begin
            if (answer_now) begin
              state      <= ST_FEEDBACK;
              fb_cnt     <= FB_LOAD;
              background <= answer_good ? BG_OK : BG_BAD;
              if (answer_good && score != SCORE_MAX)
                score <= score + 1'b1;
              ans_pend   <= 1'b0;
              ans_ok     <= 1'b0;
            end else if (frames_left == CNT_ONE) begin
              state       <= ST_FEEDBACK;
              fb_cnt      <= FB_LOAD;
              background  <= BG_BAD;
              frames_left <= '0;
              ans_pend    <= 1'b0;
              ans_ok      <= 1'b0;
            end else begin
              frames_left <= frames_left - 1'b1;
            end
          end
          ST_FEEDBACK: begin
            if (fb_cnt <= CNT_ONE) begin
              background <= BG_IDLE;
              if (q_idx == LAST_Q) begin
                state <= ST_DONE;
                q_en  <= '0;
                done  <= 1'b1;
              end else begin
                state       <= ST_SHOW;
                q_idx       <= q_idx + 1'b1;
                q_en        <= q_en << 1;
                frames_left <= TIME_LOAD;
              end
            end else begin
              fb_cnt <= fb_cnt - 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prompt_sequencer.sv
// Directed bench for prompt_sequencer with a per-cycle reference model.
module tb_prompt_sequencer;

  localparam int NQ = 3;
  localparam int TF = 4;
  localparam int FB = 2;
  localparam int HT = 8;
  localparam int VT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  hCount = '0;
  logic [9:0]  vCount = '0;
  logic        start = 1'b0;
  logic        answer_valid = 1'b0;
  logic        answer_correct = 1'b0;
  logic [2:0]  q_en;
  logic [2:0]  q_idx;
  logic [11:0] background;
  logic [3:0]  score;
  logic [9:0]  frames_left;
  logic        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prompt_sequencer #(
    .NUM_Q       (NQ),
    .IDX_W       (3),
    .CNT_W       (10),
    .TIME_FRAMES (TF),
    .FB_FRAMES   (FB),
    .H_TOTAL     (HT),
    .V_TOTAL     (VT),
    .BG_IDLE     (12'h000),
    .BG_OK       (12'h0F0),
    .BG_BAD      (12'hF00)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hCount         (hCount),
    .vCount         (vCount),
    .start          (start),
    .answer_valid   (answer_valid),
    .answer_correct (answer_correct),
    .q_en           (q_en),
    .q_idx          (q_idx),
    .background     (background),
    .score          (score),
    .frames_left    (frames_left),
    .done           (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Raster counter: advances between rising edges.
  initial begin
    forever begin
      @(negedge clk);
      if (hCount == 10'(HT - 1)) begin
        hCount = '0;
        vCount = (vCount == 10'(VT - 1)) ? '0 : vCount + 1'b1;
      end else begin
        hCount = hCount + 1'b1;
      end
    end
  end

  // Reference model: quiz described as prompt number, phase flags and counters.
  bit m_tick, m_fired;
  bit showing, flashing, finished, want_start, have_ans, ans_good, flash_good;
  int prompt, left, flash_left, m_score;
  bit was_idle, was_show, new_start, new_ans, new_good, consumed;

  task automatic model_step();
    if (!rst) begin
      m_tick = 0; m_fired = 0; showing = 0; flashing = 0; finished = 0;
      want_start = 0; have_ans = 0; ans_good = 0; flash_good = 0;
      prompt = 0; left = 0; flash_left = 0; m_score = 0;
      return;
    end
    was_idle  = !showing && !flashing;
    was_show  = showing;
    new_start = start && was_idle;
    new_ans   = answer_valid && was_show && !have_ans;
    new_good  = answer_correct;
    consumed  = 0;
    m_fired   = m_tick;
    if (m_tick) begin
      if (showing) begin
        consumed = (have_ans || answer_valid) || (left == 1);
        if (have_ans || answer_valid) begin
          flash_good = have_ans ? ans_good : answer_correct;
          if (flash_good) m_score = (m_score < 15) ? m_score + 1 : 15;
          showing = 0; flashing = 1; flash_left = FB;
        end else if (left == 1) begin
          flash_good = 0; left = 0;
          showing = 0; flashing = 1; flash_left = FB;
        end else begin
          left--;
        end
        if (consumed) begin have_ans = 0; ans_good = 0; end
      end else if (flashing) begin
        if (flash_left == 1) begin
          flashing = 0;
          if (prompt == NQ - 1) finished = 1;
          else begin prompt++; showing = 1; left = TF; end
        end else begin
          flash_left--;
        end
      end else if (want_start) begin
        showing = 1; finished = 0; prompt = 0; left = TF; m_score = 0;
        want_start = 0;
        new_start = 0;
      end
    end
    if (new_start) want_start = 1;
    if (new_ans && !consumed) begin have_ans = 1; ans_good = new_good; end
    m_tick = (hCount == 10'(HT - 1)) && (vCount == 10'(VT - 1));
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      check("q_en", q_en, (showing || flashing) ? (32'd1 << prompt) : 32'd0);
      check("q_idx", q_idx, prompt);
      check("background", background, flashing ? (flash_good ? 32'h0F0 : 32'hF00) : 32'h000);
      check("score", score, m_score);
      check("frames_left", frames_left, left);
      check("done", done, finished);
      if (q_en != 0) check("onehot", q_en, 32'd1 << q_idx);
    end
  end

  task automatic next_tick();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!m_fired && n < 100);
    if (!m_fired) begin
      checks++; errors++;
      $display("FAIL tick_wait: got no frame tick expected one within 100 cycles");
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_answer(input logic ok);
    @(negedge clk); answer_valid = 1'b1; answer_correct = ok;
    @(negedge clk); answer_valid = 1'b0; answer_correct = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 1: idle, then start
    next_tick(); next_tick();
    check("idle_q_en", q_en, 0);
    check("idle_bg", background, 12'h000);
    check("idle_done", done, 0);
    repeat (8) @(posedge clk);
    pulse_start();
    next_tick();
    check("start_q_en", q_en, 3'b001);
    check("start_q_idx", q_idx, 0);
    check("start_frames", frames_left, 4);

    // 2: correct answer on prompt 0
    repeat (5) @(posedge clk);
    pulse_answer(1'b1);
    next_tick();
    check("p0_score", score, 1);
    check("p0_bg", background, 12'h0F0);
    check("p0_q_en_held", q_en, 3'b001);
    next_tick(); next_tick();
    check("p1_q_en", q_en, 3'b010);
    check("p1_frames", frames_left, 4);
    check("p1_bg", background, 12'h000);

    // 3: timeout on prompt 1
    for (int i = 3; i >= 1; i--) begin
      next_tick();
      check("p1_countdown", frames_left, i);
    end
    next_tick();
    check("timeout_bg", background, 12'hF00);
    check("timeout_score", score, 1);
    check("timeout_frames", frames_left, 0);
    next_tick(); next_tick();
    check("p2_q_en", q_en, 3'b100);

    // 4: wrong answer coincident with the frame tick, later pulse ignored
    begin
      int n = 0;
      do begin @(posedge clk); #1; n++; end
      while (!(hCount == 10'(HT - 1) && vCount == 10'(VT - 1)) && n < 100);
      if (n >= 100) begin
        checks++; errors++;
        $display("FAIL raster_wait: got no frame end expected one within 100 cycles");
      end
    end
    @(negedge clk); answer_valid = 1'b1; answer_correct = 1'b0;
    @(posedge clk); #2;
    check("coinc_bg", background, 12'hF00);
    check("coinc_score", score, 1);
    @(negedge clk); answer_valid = 1'b0;
    repeat (5) @(posedge clk);
    pulse_answer(1'b1);
    next_tick();
    check("second_ans_score", score, 1);
    check("second_ans_bg", background, 12'hF00);

    // 5: done, then restart
    next_tick();
    check("done_flag", done, 1);
    check("done_q_en", q_en, 0);
    check("done_score", score, 1);
    check("done_bg", background, 12'h000);
    repeat (6) @(posedge clk);
    pulse_start();
    next_tick();
    check("restart_score", score, 0);
    check("restart_q_en", q_en, 3'b001);
    check("restart_done", done, 0);

    // 6: start during SHOW ignored, async reset in FEEDBACK
    repeat (5) @(posedge clk);
    pulse_start();
    next_tick();
    check("ignored_start_q_en", q_en, 3'b001);
    check("ignored_start_frames", frames_left, 3);
    repeat (5) @(posedge clk);
    pulse_answer(1'b1);
    next_tick();
    check("fb_before_rst_bg", background, 12'h0F0);
    check("fb_before_rst_score", score, 1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_q_en", q_en, 0);
    check("rst_q_idx", q_idx, 0);
    check("rst_bg", background, 12'h000);
    check("rst_score", score, 0);
    check("rst_frames", frames_left, 0);
    check("rst_done", done, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    next_tick(); next_tick();
    check("post_rst_idle", q_en, 0);
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
